// File: rtl/keypad_time_entry.sv
// 4x4 matrix keypad scanner with debounce, one-shot key events and a
// four-digit BCD shift register that presents the entered cook time in binary.
module keypad_time_entry #(
    parameter int SCAN_TICKS     = 100_000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    input  logic        entry_enable,
    input  logic        entry_clear,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic        enter_pulse,
    output logic [13:0] entry_data
);

    localparam int TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [3:0] CODE_STAR  = 4'd14;
    localparam logic [3:0] CODE_POUND = 4'd15;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

    logic [3:0]        row_meta_q, row_sync_q;
    logic [TICK_W-1:0] tick_q;
    logic [1:0]        col_idx_q;
    logic [3:0]        col_q;
    logic [1:0]        hits_q;
    logic [3:0]        code_acc_q;

    state_t            state_q;
    logic [3:0]        cand_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              key_valid_q, key_held_q, enter_pulse_q;
    logic [3:0]        key_code_q;
    logic [3:0]        dig_q [4];

    logic              last_tick, scan_done, scan_single;
    logic [3:0]        row_hit;
    logic [2:0]        col_hits, total_hits;
    logic [1:0]        row_idx;
    logic [3:0]        this_code, scan_code;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'd1;   4'h1: code = 4'd2;   4'h2: code = 4'd3;   4'h3: code = 4'd10;
            4'h4: code = 4'd4;   4'h5: code = 4'd5;   4'h6: code = 4'd6;   4'h7: code = 4'd11;
            4'h8: code = 4'd7;   4'h9: code = 4'd8;   4'hA: code = 4'd9;   4'hB: code = 4'd12;
            4'hC: code = 4'd14;  4'hD: code = 4'd0;   4'hE: code = 4'd15;  default: code = 4'd13;
        endcase
        return code;
    endfunction

    always_comb begin
        last_tick = (tick_q == TICK_W'(SCAN_TICKS - 1));
        scan_done = last_tick && (col_idx_q == 2'd3);
        row_hit   = ~row_sync_q;
        col_hits  = {2'b00, row_hit[0]} + {2'b00, row_hit[1]}
                  + {2'b00, row_hit[2]} + {2'b00, row_hit[3]};
        row_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (row_hit[i]) row_idx = 2'(i);
        end
        this_code   = key_map(row_idx, col_idx_q);
        // Hits from the final column are folded in here so the verdict is ready on the done tick.
        total_hits  = {1'b0, hits_q} + col_hits;
        scan_single = (total_hits == 3'd1);
        scan_code   = (col_hits == 3'd1) ? this_code : code_acc_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            tick_q     <= '0;
            col_idx_q  <= 2'd0;
            col_q      <= 4'b1110;
            hits_q     <= 2'd0;
            code_acc_q <= 4'd0;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
            if (last_tick) begin
                tick_q    <= '0;
                col_idx_q <= col_idx_q + 2'd1;
                col_q     <= {col_q[2:0], col_q[3]};
                if (scan_done) begin
                    hits_q <= 2'd0;
                end else begin
                    hits_q <= (total_hits >= 3'd2) ? 2'd2 : total_hits[1:0];
                    if (col_hits == 3'd1) code_acc_q <= this_code;
                end
            end else begin
                tick_q <= tick_q + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (scan_done) begin
                case (state_q)
                    IDLE: begin
                        if (scan_single) begin
                            cand_q  <= scan_code;
                            cnt_q   <= CNT_W'(1);
                            state_q <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (scan_single && scan_code == cand_q) begin
                            if (cnt_q == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                                state_q     <= HELD;
                                key_valid_q <= 1'b1;
                                key_code_q  <= cand_q;
                                key_held_q  <= 1'b1;
                                cnt_q       <= '0;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end else if (scan_single) begin
                            cand_q <= scan_code;
                            cnt_q  <= CNT_W'(1);
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    end
                    HELD: begin
                        // Release needs consecutive empty scans; any key seen restarts the count.
                        if (scan_single) begin
                            cnt_q <= '0;
                        end else if (cnt_q == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                            state_q    <= IDLE;
                            key_held_q <= 1'b0;
                            cnt_q      <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enter_pulse_q <= 1'b0;
            for (int i = 0; i < 4; i++) dig_q[i] <= 4'd0;
        end else begin
            enter_pulse_q <= key_valid_q && entry_enable && (key_code_q == CODE_POUND);
            if (entry_clear) begin
                for (int i = 0; i < 4; i++) dig_q[i] <= 4'd0;
            end else if (key_valid_q && entry_enable) begin
                if (key_code_q <= 4'd9) begin
                    dig_q[3] <= dig_q[2];
                    dig_q[2] <= dig_q[1];
                    dig_q[1] <= dig_q[0];
                    dig_q[0] <= key_code_q;
                end else if (key_code_q == CODE_STAR) begin
                    for (int i = 0; i < 4; i++) dig_q[i] <= 4'd0;
                end
            end
        end
    end

    always_comb begin
        entry_data = {10'd0, dig_q[3]} * 14'd1000 + {10'd0, dig_q[2]} * 14'd100
                   + {10'd0, dig_q[1]} * 14'd10   + {10'd0, dig_q[0]};
    end

    assign col         = col_q;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_held    = key_held_q;
    assign enter_pulse = enter_pulse_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Directed bench for keypad_time_entry: a pressed-key matrix model drives the
// rows from the DUT's column lines; expectations are hand-computed constants.
module tb_keypad_time_entry;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row;
    logic        entry_enable = 1'b0;
    logic        entry_clear = 1'b0;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic        enter_pulse;
    logic [13:0] entry_data;

    logic [15:0] pressed = 16'h0;
    int n_checks = 0;
    int n_pass   = 0;
    int vcount   = 0;
    int ecount   = 0;
    int v0, e0;
    bit found;

    keypad_time_entry #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(2)) dut (
        .clk(clk), .reset(reset), .row(row), .entry_enable(entry_enable),
        .entry_clear(entry_clear), .col(col), .key_valid(key_valid),
        .key_code(key_code), .key_held(key_held), .enter_pulse(enter_pulse),
        .entry_data(entry_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < 4; r++) row[r] = ~|(pressed[r*4 +: 4] & ~col);
    end

    always @(negedge clk) begin
        if (key_valid)   vcount++;
        if (enter_pulse) ecount++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic key_on(input int r, input int c);
        pressed[r*4 + c] = 1'b1;
    endtask

    task automatic key_off(input int r, input int c);
        pressed[r*4 + c] = 1'b0;
    endtask

    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (key_valid) seen = 1'b1;
        end
    endtask

    task automatic press(input int r, input int c, input int hold);
        key_on(r, c);
        repeat (hold) @(negedge clk);
        key_off(r, c);
        repeat (64) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_col", col, 4'b1110);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_held", key_held, 0);
        check("rst_enter", enter_pulse, 0);
        check("rst_entry", entry_data, 0);
        reset = 1'b1;
        entry_enable = 1'b1;
        repeat (4) @(negedge clk);

        // single press of '5'
        v0 = vcount;
        key_on(1, 1);
        wait_valid(found);
        check("k5_seen", found, 1);
        check("k5_code", key_code, 5);
        check("k5_held_n", key_held, 1);
        check("k5_entry_n", entry_data, 0);
        @(negedge clk);
        check("k5_entry_n1", entry_data, 5);
        check("k5_valid_1cyc", key_valid, 0);
        repeat (32) @(negedge clk);
        check("k5_held_on", key_held, 1);
        key_off(1, 1);
        repeat (64) @(negedge clk);
        check("k5_held_off", key_held, 0);
        check("k5_count", vcount - v0, 1);

        // 1,2,3,4,5 then '#' then '*'
        v0 = vcount;
        e0 = ecount;
        press(0, 0, 64);
        press(0, 1, 64);
        press(0, 2, 64);
        press(1, 0, 64);
        check("seq_1234", entry_data, 1234);
        press(1, 1, 64);
        check("seq_2345", entry_data, 2345);
        press(3, 2, 64);
        check("pound_entry", entry_data, 2345);
        check("pound_code", key_code, 15);
        check("pound_pulse", ecount - e0, 1);
        press(3, 0, 64);
        check("star_entry", entry_data, 0);
        check("seq_count", vcount - v0, 7);

        // one-scan glitch
        v0 = vcount;
        press(2, 1, 12);
        check("glitch_count", vcount - v0, 0);
        check("glitch_held", key_held, 0);

        // '1' and '6' together, then '6' released
        v0 = vcount;
        key_on(0, 0);
        key_on(1, 2);
        repeat (64) @(negedge clk);
        check("multi_count", vcount - v0, 0);
        key_off(1, 2);
        repeat (64) @(negedge clk);
        check("multi_rel_count", vcount - v0, 1);
        check("multi_rel_code", key_code, 1);
        key_off(0, 0);
        repeat (64) @(negedge clk);
        check("multi_entry", entry_data, 1);

        // long hold of '7' with entry disabled
        entry_enable = 1'b0;
        v0 = vcount;
        key_on(2, 0);
        repeat (320) @(negedge clk);
        check("hold7_held", key_held, 1);
        key_off(2, 0);
        repeat (64) @(negedge clk);
        check("hold7_count", vcount - v0, 1);
        check("hold7_code", key_code, 7);
        check("hold7_entry", entry_data, 1);

        // entry_clear coincident with accept of '9'
        entry_enable = 1'b1;
        press(3, 0, 64);
        press(0, 0, 64);
        press(0, 1, 64);
        check("pre_clear_12", entry_data, 12);
        key_on(2, 2);
        wait_valid(found);
        check("k9_seen", found, 1);
        check("k9_code", key_code, 9);
        entry_clear = 1'b1;
        @(negedge clk);
        entry_clear = 1'b0;
        check("clear_wins", entry_data, 0);
        key_off(2, 2);
        repeat (64) @(negedge clk);
        check("clear_stays", entry_data, 0);

        // reset in the middle of a debounce
        press(1, 0, 64);
        check("pre_rst_entry", entry_data, 4);
        key_on(0, 2);
        repeat (14) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_col", col, 4'b1110);
        check("mid_rst_valid", key_valid, 0);
        check("mid_rst_code", key_code, 0);
        check("mid_rst_held", key_held, 0);
        check("mid_rst_enter", enter_pulse, 0);
        check("mid_rst_entry", entry_data, 0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        wait_valid(found);
        check("post_rst_seen", found, 1);
        check("post_rst_code", key_code, 3);
        @(negedge clk);
        check("post_rst_entry", entry_data, 3);
        key_off(0, 2);
        repeat (64) @(negedge clk);
        check("post_rst_held", key_held, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_time_entry.md
Name: keypad_time_entry

Overview:
- Input-side counterpart of the FND display path: scans a 4x4 matrix keypad by driving active-low column lines and sampling active-low row lines.
- Debounces presses, emits one-cycle key events and accumulates decimal digits into a 14-bit cook-time value (0~9999).
- That value feeds the oven control FSM and, from there, the FND controller's input_data.

Parameters:
- SCAN_TICKS, 100_000, clocks per column drive period (1 ms at 100 MHz).
- DEBOUNCE_SCANS, 5, consecutive full 4-column scans required to accept a press or a release.

Ports:
- clk  input  1  100 MHz system clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- entry_enable  input  1  1 = digit/clear keys modify entry_data
- entry_clear  input  1  synchronous clear of accumulated digits
- col  output  4  keypad column drive, active-low, exactly one bit low
- key_valid  output  1  one-cycle pulse per accepted press
- key_code  output  4  code of last accepted key; held until next accept
- key_held  output  1  1 while an accepted key has not been released
- enter_pulse  output  1  one-cycle pulse when '#' is accepted and entry_enable=1
- entry_data  output  14  binary value of accumulated digits, 0~9999

Behaviour:
- Reset (reset=0, async): col=4'b1110, key_valid=0, key_code=0, key_held=0, enter_pulse=0, entry_data=0, BCD digits=0, state=IDLE, all counters 0.
- Row inputs go through a 2-FF synchronizer before any use.
- Column scan runs continuously in every state.
  - col rotates 1110→1101→1011→0111→1110, one step every SCAN_TICKS clocks.
  - Synchronized rows are sampled on the last tick of each column period.
  - A full scan completes after the column 3 sample.
- Scan result per full scan:
  - NONE: no zero bits seen.
  - SINGLE(code): exactly one row/column intersection seen.
  - MULTI: two or more seen. MULTI is treated as NONE.
- Key map [row][col], row0..3 by col0..3:
  - row0: 1, 2, 3, A
  - row1: 4, 5, 6, B
  - row2: 7, 8, 9, C
  - row3: *, 0, #, D
  - Codes: digits = value, A=10, B=11, C=12, D=13, *=14, #=15.
- FSM, evaluated at scan completion only:
  - IDLE: SINGLE(c) → DEBOUNCE, cand=c, cnt=1.
  - DEBOUNCE: SINGLE(cand) → cnt+1. When cnt reaches DEBOUNCE_SCANS: accept, go HELD. SINGLE(other) → restart with new cand, cnt=1. NONE → IDLE.
  - HELD: key_held=1. NONE → cnt+1. Any key → cnt=0. When cnt reaches DEBOUNCE_SCANS: go IDLE, key_held=0.
- Accept cycle N:
  - key_valid=1 in cycle N only.
  - key_code updated to cand, visible in cycle N.
  - key_held=1 from cycle N.
- Entry update on the accept edge, visible in cycle N+1, only when entry_enable=1:
  - Digit d: {d1000,d100,d10,d1} ← {d100,d10,d1,d}. The thousands digit is dropped, so after 9999, pressing 1 gives 9991.
  - '*': all digits ← 0.
  - '#': enter_pulse=1 in cycle N+1, entry unchanged.
  - A-D: no entry effect.
- entry_enable=0: key_valid and key_code still operate; entry_data and enter_pulse are unaffected.
- entry_data = d1000*1000 + d100*100 + d10*10 + d1, combinational from the digit registers. Its maximum is 9999, which fits 14 bits.
- entry_clear=1: digits ← 0 on next edge regardless of entry_enable. It wins over a simultaneous digit accept.
- A held key generates exactly one key_valid. Re-press requires passing through IDLE.
- Reset asserted mid-press: immediate return to reset values. A key still held after release of reset is accepted fresh after DEBOUNCE_SCANS scans.

Test Plan:
Bench parameters for all scenarios: SCAN_TICKS=4, DEBOUNCE_SCANS=2.
- Press '5' (row1 low while col=1101) for 4 scans, then release → one key_valid, key_code=5, entry_data=5 next cycle, key_held=1→0 after 2 empty scans.
- With entry_enable=1, press 1,2,3,4,5 then '#' → entry_data=2345, one enter_pulse. Then '*' → entry_data=0.
- Row glitch lasting 1 scan → no key_valid, state returns to IDLE.
- Keys '1' and '6' held together → no key_valid. Release '6', keep '1' → key_valid, code=1.
- Hold '7' for 20 scans → exactly one key_valid. With entry_enable=0, entry_data unchanged.
- entry_clear asserted in the same cycle as accept of '9' with entry_data=12 → entry_data=0. Separately, assert reset mid-DEBOUNCE → all outputs 0 and col=1110.
